// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C EEPROM slave: FSM state encoding, default
// device address and small byte helpers.
package i2c_pkg;

  localparam logic [6:0] I2C_DEV_ADDR = 7'b1010000;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV       = 4'd1,
    DEV_ACK   = 4'd2,
    ADDR      = 4'd3,
    ADDR_ACK  = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RACK      = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
    return {sr[6:0], b};
  endfunction

  function automatic logic is_ack_state(input state_t s);
    return (s == DEV_ACK) || (s == ADDR_ACK) || (s == WDATA_ACK);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Brings scl/sda into the clk domain and derives scl edges plus START/STOP.
// Events are combinational from the last sync stage and the edge register.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_chain;
  logic [SYNC_STAGES-1:0] sda_chain;
  logic                   scl_last;
  logic                   sda_last;
  logic                   scl_now;
  logic                   sda_now;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_chain <= '1;
      sda_chain <= '1;
      scl_last  <= 1'b1;
      sda_last  <= 1'b1;
    end else begin
      scl_chain[0] <= scl_pin;
      sda_chain[0] <= sda_pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_chain[i] <= scl_chain[i-1];
        sda_chain[i] <= sda_chain[i-1];
      end
      scl_last <= scl_now;
      sda_last <= sda_now;
    end
  end

  assign scl_now   = scl_chain[SYNC_STAGES-1];
  assign sda_now   = sda_chain[SYNC_STAGES-1];
  assign sda_level = sda_now;

  assign scl_rise = scl_now & ~scl_last;
  assign scl_fall = ~scl_now & scl_last;
  // Only a data transition under a stable-high clock is a bus condition.
  assign start    = scl_now & scl_last & sda_last & ~sda_now;
  assign stop     = scl_now & scl_last & ~sda_last & sda_now;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 256x8 I2C EEPROM-style slave: byte/sequential writes, random and
// current-address sequential reads with an auto-incrementing pointer.
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;
  logic [7:0] ptr;
  logic [7:0] ptr_nxt;
  logic       sda_oe;
  logic       sda_oe_nxt;
  logic       busy_nxt;
  logic       rw;
  logic       rw_nxt;
  logic       wr_strobe_nxt;
  logic [7:0] wr_addr_nxt;
  logic [7:0] wr_data_nxt;
  logic       mem_we;
  logic [7:0] rx_byte;
  logic [7:0] mem_rd;

  logic [7:0] mem [256];

  i2c_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .scl_pin  (scl),
    .sda_pin  (sda),
    .sda_level(sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign rx_byte = shift_in(shreg, sda_s);
  assign mem_rd  = mem[ptr];

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    shreg_nxt     = shreg;
    ptr_nxt       = ptr;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy;
    rw_nxt        = rw;
    wr_strobe_nxt = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    mem_we        = 1'b0;

    if (start) begin
      state_nxt  = DEV;
      cnt_nxt    = 4'd0;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b1;
    end else if (stop) begin
      state_nxt  = IDLE;
      cnt_nxt    = 4'd0;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (is_ack_state(state)) begin
      // cnt 0: waiting for the fall after bit 8; cnt 1: ACK held until next fall
      if (scl_fall) begin
        if (cnt == 4'd0) begin
          sda_oe_nxt = 1'b1;
          cnt_nxt    = 4'd1;
        end else begin
          sda_oe_nxt = 1'b0;
          cnt_nxt    = 4'd0;
          if (state == DEV_ACK && rw) begin
            state_nxt  = RDATA;
            shreg_nxt  = mem_rd;
            sda_oe_nxt = ~mem_rd[7];
          end else if (state == DEV_ACK) begin
            state_nxt = ADDR;
          end else begin
            state_nxt = WDATA;
          end
        end
      end
    end else begin
      case (state)
        DEV: begin
          if (scl_rise) begin
            shreg_nxt = rx_byte;
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_nxt   = 4'd0;
              rw_nxt    = rx_byte[0];
              state_nxt = (rx_byte[7:1] == DEV_ADDR) ? DEV_ACK : WAIT_STOP;
            end
          end
        end
        ADDR: begin
          if (scl_rise) begin
            shreg_nxt = rx_byte;
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_nxt   = 4'd0;
              ptr_nxt   = rx_byte;
              state_nxt = ADDR_ACK;
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shreg_nxt = rx_byte;
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_nxt       = 4'd0;
              mem_we        = 1'b1;
              wr_strobe_nxt = 1'b1;
              wr_addr_nxt   = ptr;
              wr_data_nxt   = rx_byte;
              ptr_nxt       = ptr + 8'd1;
              state_nxt     = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          // cnt counts bits the master has sampled; drive changes on falls only
          if (scl_rise) begin
            cnt_nxt = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              cnt_nxt    = 4'd0;
              sda_oe_nxt = 1'b0;
              state_nxt  = RACK;
            end else begin
              shreg_nxt  = {shreg[6:0], 1'b0};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise && cnt == 4'd0) begin
            ptr_nxt = ptr + 8'd1;
            if (sda_s) begin
              state_nxt = WAIT_STOP;
            end else begin
              cnt_nxt = 4'd1;
            end
          end else if (scl_fall && cnt == 4'd1) begin
            cnt_nxt    = 4'd0;
            shreg_nxt  = mem_rd;
            sda_oe_nxt = ~mem_rd[7];
            state_nxt  = RDATA;
          end
        end
        IDLE, WAIT_STOP: begin
          sda_oe_nxt = 1'b0;
        end
        default: begin
          state_nxt  = IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ptr       <= 8'd0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rw        <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      rw        <= rw_nxt;
      wr_strobe <= wr_strobe_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: a bit-banged master drives the bus,
// expected writes/ACKs/read bytes are queued and checked by monitor processes.
module tb_i2c_eeprom_slave;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       scl;
  logic       m_sda_low;
  wire        sda;
  logic       busy;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  string       name_q[$];
  logic [7:0]  obs_q[$];
  event        obs_ev;

  always #5 clk = ~clk;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_eeprom_slave #(
    .DEV_ADDR   (7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .scl      (scl),
    .sda      (sda),
    .busy     (busy),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Write-commit monitor
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_strobe_unexpected actual=%h required=none", {wr_addr, wr_data});
      end else begin
        check("wr_commit", {wr_addr, wr_data}, exp_wr_q.pop_front());
      end
    end
  end

  // ACK / read-byte monitor
  initial begin
    forever begin
      @(obs_ev);
      while (obs_q.size() > 0 && exp_rd_q.size() > 0) begin
        check(name_q.pop_front(), {8'h00, obs_q.pop_front()}, {8'h00, exp_rd_q.pop_front()});
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bit_cycle(input logic drive_low, output logic sampled);
    m_sda_low = drive_low;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    #1 sampled = sda;
    clks(Q);
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    m_sda_low = 1'b1;
    clks(Q);
    scl = 1'b0;
    clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    m_sda_low = 1'b0;
    clks(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic s;
    exp_rd_q.push_back({7'd0, exp_ack});
    name_q.push_back(nm);
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
    bit_cycle(1'b0, s);
    obs_q.push_back({7'd0, s});
    ->obs_ev;
  endtask

  task automatic rbyte(input logic [7:0] exp, input logic nack, input string nm);
    logic [7:0] v;
    logic       s;
    exp_rd_q.push_back(exp);
    name_q.push_back(nm);
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b0, s);
      v[i] = s;
    end
    obs_q.push_back(v);
    ->obs_ev;
    bit_cycle(~nack, s);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s;
    rstn      = 1'b0;
    scl       = 1'b1;
    m_sda_low = 1'b0;
    clks(3);
    @(negedge clk);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_wr_strobe", 16'(wr_strobe), 16'd0);
    check("reset_wr_addr", 16'(wr_addr), 16'd0);
    check("reset_wr_data", 16'(wr_data), 16'd0);
    check("reset_sda_released", 16'(sda), 16'd1);
    rstn = 1'b1;
    clks(4);

    // Byte write 0x5A to 0x3C
    exp_wr_q.push_back(16'h3C5A);
    i2c_start();
    check("busy_after_start", 16'(busy), 16'd1);
    wbyte(8'hA0, 1'b0, "ack_dev_w");
    wbyte(8'h3C, 1'b0, "ack_addr_3c");
    wbyte(8'h5A, 1'b0, "ack_data_5a");
    i2c_stop();
    check("busy_after_stop", 16'(busy), 16'd0);

    // Random read of 0x3C through a repeated START
    i2c_start();
    wbyte(8'hA0, 1'b0, "ack_dev_w2");
    wbyte(8'h3C, 1'b0, "ack_addr_3c_2");
    i2c_start();
    wbyte(8'hA1, 1'b0, "ack_dev_r");
    rbyte(8'h5A, 1'b1, "rd_3c");
    i2c_stop();

    // Address mismatch: slave stays silent
    i2c_start();
    wbyte(8'hA2, 1'b1, "nack_dev_mismatch");
    wbyte(8'h3C, 1'b1, "silent_addr");
    wbyte(8'h77, 1'b1, "silent_data");
    i2c_stop();
    check("busy_after_mismatch", 16'(busy), 16'd0);

    // Sequential write across the 0xFF -> 0x00 wrap
    exp_wr_q.push_back(16'hFF11);
    exp_wr_q.push_back(16'h0022);
    i2c_start();
    wbyte(8'hA0, 1'b0, "ack_dev_wrap_w");
    wbyte(8'hFF, 1'b0, "ack_addr_ff");
    wbyte(8'h11, 1'b0, "ack_data_11");
    wbyte(8'h22, 1'b0, "ack_data_22");
    i2c_stop();

    // Sequential read across the wrap
    i2c_start();
    wbyte(8'hA0, 1'b0, "ack_dev_wrap_rw");
    wbyte(8'hFF, 1'b0, "ack_addr_ff_2");
    i2c_start();
    wbyte(8'hA1, 1'b0, "ack_dev_wrap_r");
    rbyte(8'h11, 1'b0, "rd_ff");
    rbyte(8'h22, 1'b1, "rd_00");
    i2c_stop();

    // Preload 0x40 with 0x00 so the slave pulls low on every read bit
    exp_wr_q.push_back(16'h4000);
    i2c_start();
    wbyte(8'hA0, 1'b0, "ack_dev_pre");
    wbyte(8'h40, 1'b0, "ack_addr_40");
    wbyte(8'h00, 1'b0, "ack_data_00");
    i2c_stop();

    // Reset during the read data phase
    i2c_start();
    wbyte(8'hA0, 1'b0, "ack_dev_rst_w");
    wbyte(8'h40, 1'b0, "ack_addr_40_2");
    i2c_start();
    wbyte(8'hA1, 1'b0, "ack_dev_rst_r");
    for (int i = 0; i < 3; i++) begin
      bit_cycle(1'b0, s);
      check("rd_bit_before_reset", 16'(s), 16'd0);
    end
    clks(Q);
    @(negedge clk);
    check("sda_driven_before_reset", 16'(sda), 16'd0);
    rstn = 1'b0;
    #1;
    check("sda_released_on_reset", 16'(sda), 16'd1);
    check("busy_on_reset", 16'(busy), 16'd0);
    check("wr_addr_on_reset", 16'(wr_addr), 16'd0);
    clks(2);
    rstn = 1'b1;
    clks(2);
    i2c_stop();

    // Current-address read: pointer restarts at 0 after reset
    i2c_start();
    wbyte(8'hA1, 1'b0, "ack_dev_cur_r");
    rbyte(8'h22, 1'b1, "rd_cur_ptr0");
    i2c_stop();

    // Full write/read transaction after reset
    exp_wr_q.push_back(16'h40C3);
    i2c_start();
    wbyte(8'hA0, 1'b0, "ack_dev_post_w");
    wbyte(8'h40, 1'b0, "ack_addr_post");
    wbyte(8'hC3, 1'b0, "ack_data_c3");
    i2c_stop();
    i2c_start();
    wbyte(8'hA0, 1'b0, "ack_dev_post_rw");
    wbyte(8'h40, 1'b0, "ack_addr_post_2");
    i2c_start();
    wbyte(8'hA1, 1'b0, "ack_dev_post_r");
    rbyte(8'hC3, 1'b1, "rd_post_40");
    i2c_stop();

    clks(20);
    check("pending_writes", 16'(exp_wr_q.size()), 16'd0);
    check("pending_reads", 16'(exp_rd_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
